// File: rtl/apb_pkg.sv
// Shared APB constants and the completer FSM state type.
package apb_pkg;
  localparam int APB_ADDR_WIDTH = 12;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int APB_WAIT_CNT_W = 4;
  localparam logic [31:0] APB_ID_VALUE = 32'hA9B0_0001;

  typedef enum logic {IDLE, ACCESS} completer_state_e;
endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: byte-strobed writes, combinational read mux.
// Register 0 is loaded with ID_VALUE at reset and never written.
module apb_reg_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_REGS   = 16,
  parameter int                    IDX_W      = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = '0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic [DATA_WIDTH-1:0] rdata
);
  // Rounded up to a power of two so any idx value selects a defined entry.
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
      regs[0] <= ID_VALUE;
    end else if (we && idx != '0) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b]) regs[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = regs[idx];
endmodule

// File: rtl/apb_reg_completer.sv
// APB completer: register bank with byte strobes, programmable wait states, PSLVERR decode.
// Define APB_PROT_CHECK_EN to reject unprivileged (pprot[0]==0) accesses.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = APB_ID_VALUE
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  input  logic [2:0]            pprot,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int IW    = ADDR_WIDTH - OFF_W;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0]             NREGS = IW'(NUM_REGS);
  localparam logic [APB_WAIT_CNT_W-1:0] WS    = APB_WAIT_CNT_W'(WAIT_STATES);
  localparam logic [APB_WAIT_CNT_W-1:0] ONE   = APB_WAIT_CNT_W'(1);

  completer_state_e          state, state_n;
  logic [APB_WAIT_CNT_W-1:0] cnt, cnt_n;
  logic                      pready_n, pslverr_n, we;
  logic [DATA_WIDTH-1:0]     prdata_n, rdata;

  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_WIDTH-1:0] cap_strb;

  // Decode from the live bus in IDLE so a zero-wait response can be registered at the SETUP edge.
  logic                  setup, d_write, prot_err, err;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [IW-1:0]         idx_full;
  logic [DATA_WIDTH-1:0] resp_data;

  assign setup    = (state == IDLE) && psel && !penable;
  assign d_addr   = (state == IDLE) ? paddr  : cap_addr;
  assign d_write  = (state == IDLE) ? pwrite : cap_write;
  assign idx_full = d_addr[ADDR_WIDTH-1:OFF_W];

`ifdef APB_PROT_CHECK_EN
  logic cap_priv;
  assign prot_err = !((state == IDLE) ? pprot[0] : cap_priv);
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn)   cap_priv <= 1'b0;
    else if (setup) cap_priv <= pprot[0];
`else
  logic unused_prot;
  assign unused_prot = ^pprot;
  assign prot_err    = 1'b0;
`endif

  assign err = (d_addr[OFF_W-1:0] != '0) || prot_err || (idx_full >= NREGS) ||
               (d_write && idx_full == '0);
  assign resp_data = (d_write || err) ? '0 : rdata;

  apb_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH), .NUM_REGS(NUM_REGS),
    .IDX_W(IDX_W), .ID_VALUE(ID_VALUE)
  ) u_bank (
    .pclk(pclk), .presetn(presetn), .we(we), .idx(idx_full[IDX_W-1:0]),
    .wdata(cap_wdata), .wstrb(cap_strb), .rdata(rdata)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    we        = 1'b0;
    case (state)
      IDLE: if (setup) begin
        state_n = ACCESS;
        cnt_n   = WS;
        if (WAIT_STATES == 0) begin
          pready_n  = 1'b1;
          pslverr_n = err;
          prdata_n  = resp_data;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (pready) begin
          state_n = IDLE;
          we      = penable && cap_write && !err;
        end else if (penable) begin
          if (cnt == ONE) begin
            cnt_n     = '0;
            pready_n  = 1'b1;
            pslverr_n = err;
            prdata_n  = resp_data;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
      prdata  <= prdata_n;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else if (setup) begin
      cap_addr  <= paddr;
      cap_write <= pwrite;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
    end
  end
endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench: two completers (0 and 3 wait states) driven by a transfer task,
// expectations from an array-based register model, checked by an independent monitor.
module tb_apb_reg_completer;
  logic        pclk = 1'b0;
  logic        presetn [2];
  logic [11:0] paddr   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  always #5 pclk = ~pclk;

  apb_reg_completer #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn[0]), .paddr(paddr[0]), .psel(psel[0]),
    .penable(penable[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .pprot(pprot[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

  apb_reg_completer #(.WAIT_STATES(3)) dut1 (
    .pclk(pclk), .presetn(presetn[1]), .paddr(paddr[1]), .psel(psel[1]),
    .penable(penable[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .pprot(pprot[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [2][16];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic void model_reset(input int d);
    for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
    mem[d][0] = 32'hA9B0_0001;
  endfunction

  // Architectural model: error rules, then read or strobed write on the register array.
  function automatic void model(input int d, input logic [11:0] a, input logic w,
                                input logic [31:0] wd, input logic [3:0] s, input logic [2:0] p,
                                output logic [31:0] rd, output logic er);
    int  idx;
    logic pe;
    idx = int'(a) / 4;
`ifdef APB_PROT_CHECK_EN
    pe = (p[0] == 1'b0);
`else
    pe = 1'b0;
`endif
    er = (a % 4 != 0) || pe || (idx >= 16) || (w && idx == 0);
    rd = 32'h0;
    if (!er && !w) rd = mem[d][idx];
    if (!er && w)
      for (int b = 0; b < 4; b++) if (s[b]) mem[d][idx][8*b +: 8] = wd[8*b +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      if (presetn[d] === 1'b1) begin
        checks++;
        if (pready[d] === 1'b1) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pready d=%0d at cycle %0d, no transfer pending", d, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.d != d || prdata[d] !== e.data || pslverr[d] !== e.err || cyc != e.cyc) begin
              errors++;
              $display("FAIL resp d=%0d(exp %0d) prdata=%h exp %h pslverr=%b exp %b cycle=%0d exp %0d",
                       d, e.d, prdata[d], e.data, pslverr[d], e.err, cyc, e.cyc);
            end
          end
        end else if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0 || pready[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_out d=%0d prdata=%h pslverr=%b pready=%b expected 0/0/0",
                   d, prdata[d], pslverr[d], pready[d]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic xfer(input int d, input logic [11:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] s, input logic [2:0] p);
    exp_t e;
    int   t;
    model(d, a, w, wd, s, p, e.data, e.err);
    e.d   = d;
    e.cyc = cyc + 1 + ws(d);
    sb.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = w;
    pwdata[d] = wd; pstrb[d] = s; pprot[d] = p;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge pclk);
      if (pready[d] === 1'b1) break;
    end
    if (t == 20) begin
      checks++; errors++;
      $display("FAIL timeout d=%0d addr=%h: no pready within 20 cycles, expected %0d", d, a, ws(d) + 1);
    end
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic directed(input int d);
    xfer(d, 12'h000, 1'b0, 32'h0, 4'h0, 3'b001);                 // ID register
    xfer(d, 12'h004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001);
    xfer(d, 12'h004, 1'b0, 32'h0, 4'h0, 3'b001);                 // back-to-back readback
    xfer(d, 12'h008, 1'b1, 32'h1122_3344, 4'b0101, 3'b001);
    xfer(d, 12'h008, 1'b0, 32'h0, 4'h0, 3'b001);
    xfer(d, 12'h006, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001);         // misaligned
    xfer(d, 12'h040, 1'b0, 32'h0, 4'h0, 3'b001);                 // beyond last register
    xfer(d, 12'h000, 1'b1, 32'h1234_5678, 4'hF, 3'b001);         // read-only ID
    xfer(d, 12'h000, 1'b0, 32'h0, 4'h0, 3'b001);
    xfer(d, 12'h004, 1'b0, 32'h0, 4'h0, 3'b001);
    xfer(d, 12'h004, 1'b1, 32'h5555_AAAA, 4'hF, 3'b000);         // unprivileged
    xfer(d, 12'h004, 1'b0, 32'h0, 4'h0, 3'b001);
    xfer(d, 12'h004, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b001);
    xfer(d, 12'h004, 1'b1, 32'hFFFF_FFFF, 4'h0, 3'b001);         // zero-strobe no-op
    idle(1);
    xfer(d, 12'h004, 1'b0, 32'h0, 4'h0, 3'b001);
    // ACCESS markers without a SETUP must be ignored
    psel[d] = 1'b1; penable[d] = 1'b1; paddr[d] = 12'h00C; pwrite[d] = 1'b1;
    pwdata[d] = 32'hCAFE_CAFE; pstrb[d] = 4'hF;
    idle(3);
    psel[d] = 1'b0;
    idle(2);
    penable[d] = 1'b0;
    xfer(d, 12'h00C, 1'b0, 32'h0, 4'h0, 3'b001);
  endtask

  task automatic random_run(input int d, input int n);
    logic [11:0] a;
    logic [2:0]  p;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 12'($urandom_range(0, 63) | 1);
        1:       a = 12'(64 + 4 * $urandom_range(0, 1000));
        default: a = 12'(4 * $urandom_range(0, 15));
      endcase
      p = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), p);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = '0;
      pwrite[d] = 1'b0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
      model_reset(d);
    end
    idle(3);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_out%0d", d), {prdata[d][30:0], pready[d], pslverr[d]}, 32'h0);
    presetn[0] = 1'b1; presetn[1] = 1'b1;
    idle(2);

    directed(0);
    directed(1);

    // Abort in ACCESS on the wait-state completer: psel drops, nothing is written
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 12'h014; pwrite[1] = 1'b1;
    pwdata[1] = 32'h7777_7777; pstrb[1] = 4'hF; pprot[1] = 3'b001;
    idle(1);
    penable[1] = 1'b1;
    idle(1);
    psel[1] = 1'b0; penable[1] = 1'b0;
    idle(4);
    xfer(1, 12'h014, 1'b0, 32'h0, 4'h0, 3'b001);

    // Reset landing in the zero-wait pready cycle of a read
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 12'h004; pwrite[0] = 1'b0; pprot[0] = 3'b001;
    idle(1);
    penable[0] = 1'b1;
    #1 presetn[0] = 1'b0;
    #1 chk("rst_mid_prdata", prdata[0], 32'h0);
    chk("rst_mid_flags", {30'h0, pready[0], pslverr[0]}, 32'h0);
    model_reset(0);
    idle(1);
    psel[0] = 1'b0; penable[0] = 1'b0; presetn[0] = 1'b1;
    xfer(0, 12'h000, 1'b0, 32'h0, 4'h0, 3'b001);
    xfer(0, 12'h004, 1'b0, 32'h0, 4'h0, 3'b001);

    // Reset during the wait of a write: the write is discarded
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 12'h010; pwrite[1] = 1'b1;
    pwdata[1] = 32'hAABB_CCDD; pstrb[1] = 4'hF; pprot[1] = 3'b001;
    idle(1);
    penable[1] = 1'b1;
    idle(2);
    presetn[1] = 1'b0;
    #1 chk("rst_wait_flags", {30'h0, pready[1], pslverr[1]}, 32'h0);
    model_reset(1);
    idle(1);
    psel[1] = 1'b0; penable[1] = 1'b0; presetn[1] = 1'b1;
    xfer(1, 12'h010, 1'b0, 32'h0, 4'h0, 3'b001);
    xfer(1, 12'h000, 1'b0, 32'h0, 4'h0, 3'b001);

    random_run(0, 80);
    random_run(1, 60);

    idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
